// File: rtl/test_pkg.sv
// Shared constants and helper functions for the binary/Gray code converter.
package test_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  function automatic logic [15:0] width_mask(int unsigned w);
    return (w >= 16) ? 16'hffff : 16'((17'd1 << w) - 17'd1);
  endfunction

  function automatic logic [15:0] bin2gray(logic [15:0] x, int unsigned w);
    logic [15:0] m;
    m = x & width_mask(w);
    return m ^ (m >> 1);
  endfunction

  // Bits above w are masked to zero, so a full 16-bit prefix XOR from bit 15 is exact.
  function automatic logic [15:0] gray2bin(logic [15:0] g, int unsigned w);
    logic [15:0] m;
    logic [15:0] b;
    m = g & width_mask(w);
    b = '0;
    b[15] = m[15];
    for (int k = 14; k >= 0; k--) begin
      b[k] = b[k+1] ^ m[k];
    end
    return b;
  endfunction

  function automatic logic popcount_gt1(logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/gray_codec.sv
// Combinational binary->Gray and Gray->binary conversion of the same input word.
module gray_codec
  import test_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] code,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  assign gray   = WIDTH'(bin2gray(16'(code), WIDTH));
  assign binary = WIDTH'(gray2bin(16'(code), WIDTH));

endmodule

// File: rtl/test.sv
// Registered 3-bit (parameterisable) binary/Gray converter.
// Optional step checker enabled by defining TEST_GRAY_STEP_CHECK_EN.
module test
  import test_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O1,
`ifdef TEST_GRAY_STEP_CHECK_EN
  output logic             step_err,
`endif
  output logic [WIDTH-1:0] O2
);

  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] binary;

  gray_codec #(
    .WIDTH(WIDTH)
  ) u_gray_codec (
    .code  (I),
    .gray  (gray),
    .binary(binary)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O1 <= '0;
      O2 <= '0;
    end else begin
      O1 <= gray;
      O2 <= binary;
    end
  end

`ifdef TEST_GRAY_STEP_CHECK_EN
  // O1 still holds the previous Gray value at the capture edge, so it serves as the history.
  logic step_err_d;

  always_comb begin
    step_err_d = popcount_gt1(16'(gray ^ O1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_err <= 1'b0;
    end else begin
      step_err <= step_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_test.sv
// Directed self-checking bench for the registered binary/Gray converter (WIDTH=3).
module tb_test;

  localparam int unsigned W = 3;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] I;
  logic [W-1:0] O1;
  logic [W-1:0] O2;
`ifdef TEST_GRAY_STEP_CHECK_EN
  logic         step_err;
`endif

  int checks;
  int failures;

  // Hand-computed: index is I; entries are bin->Gray and Gray->bin of I.
  localparam logic [2:0] G_TAB [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                       3'b110, 3'b111, 3'b101, 3'b100};
  localparam logic [2:0] B_TAB [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                       3'b111, 3'b110, 3'b100, 3'b101};

  test #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .I       (I),
    .O1      (O1),
`ifdef TEST_GRAY_STEP_CHECK_EN
    .step_err(step_err),
`endif
    .O2      (O2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    I = 3'b101;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (O1 !== 3'b000 || O2 !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d O1=%b O2=%b required 000/000", c, O1, O2);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (O1 !== 3'b111 || O2 !== 3'b110) begin
      failures++;
      $display("FAIL reset_first_capture O1=%b O2=%b required 111/110", O1, O2);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      I = v;
      tick();
      checks++;
      if (O1 !== G_TAB[i] || O2 !== B_TAB[i]) begin
        failures++;
        $display("FAIL sweep I=%b O1=%b O2=%b required %b/%b", v, O1, O2, G_TAB[i], B_TAB[i]);
      end
    end
  endtask

  task automatic test_latency();
    I = 3'b011;
    tick();
    I = 3'b111;
    #2;
    checks++;
    if (O1 !== 3'b010) begin
      failures++;
      $display("FAIL latency_hold O1=%b required 010", O1);
    end
    tick();
    checks++;
    if (O1 !== 3'b100 || O2 !== 3'b101) begin
      failures++;
      $display("FAIL latency_update O1=%b O2=%b required 100/101", O1, O2);
    end
  endtask

  task automatic test_round_trip();
    logic [2:0] g;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      I = v;
      tick();
      g = O1;
      checks++;
      if (g !== G_TAB[i]) begin
        failures++;
        $display("FAIL round_trip_gray I=%b O1=%b required %b", v, g, G_TAB[i]);
      end
      I = g;
      tick();
      checks++;
      if (O2 !== v) begin
        failures++;
        $display("FAIL round_trip_bin orig=%b O2=%b required %b", v, O2, v);
      end
    end
  endtask

  task automatic test_async_reset();
    I = 3'b110;
    tick();
    checks++;
    if (O1 !== 3'b101 || O2 !== 3'b100) begin
      failures++;
      $display("FAIL pre_reset O1=%b O2=%b required 101/100", O1, O2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (O1 !== 3'b000 || O2 !== 3'b000) begin
      failures++;
      $display("FAIL async_clear O1=%b O2=%b required 000/000", O1, O2);
    end
    tick();
    rst_n = 1'b1;
    I = 3'b010;
    tick();
    checks++;
    if (O1 !== 3'b011 || O2 !== 3'b011) begin
      failures++;
      $display("FAIL post_reset O1=%b O2=%b required 011/011", O1, O2);
    end
  endtask

`ifdef TEST_GRAY_STEP_CHECK_EN
  task automatic test_step_check();
    logic [2:0] v;
    rst_n = 1'b0;
    I = 3'b000;
    tick();
    checks++;
    if (step_err !== 1'b0) begin
      failures++;
      $display("FAIL step_reset step_err=%b required 0", step_err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      v = 3'(i % 8);
      I = v;
      tick();
      checks++;
      if (step_err !== 1'b0) begin
        failures++;
        $display("FAIL step_count I=%b step_err=%b required 0", v, step_err);
      end
    end
    I = 3'b000;
    tick();
    I = 3'b101;
    tick();
    checks++;
    if (step_err !== 1'b1) begin
      failures++;
      $display("FAIL step_jump step_err=%b required 1", step_err);
    end
    I = 3'b100;
    tick();
    checks++;
    if (step_err !== 1'b0) begin
      failures++;
      $display("FAIL step_single step_err=%b required 0", step_err);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    I = '0;
    test_reset();
    test_sweep();
    test_latency();
    test_round_trip();
    test_async_reset();
`ifdef TEST_GRAY_STEP_CHECK_EN
    test_step_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
